// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 by default, optional even parity
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit, plus the parity_err output.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (4..65535)
//   DATA_WIDTH    data bits per frame, sent LSB first
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rx_vld      one-cycle pulse, rx_data holds a newly received good frame
//   rx_data     last good received word, held until the next good frame
//   frame_err   one-cycle pulse, stop bit sampled low
//   busy        high whenever the receiver is not idle
//   parity_err  (UART_RX_PARITY_EN only) one-cycle pulse, parity mismatch

module uart_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  rx_vld,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  frame_err,
    output logic                  busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int CNT_W = 16;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } state_t;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset release never looks like a start edge.
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [DATA_WIDTH-1:0]  shift, shift_n;
    logic [DATA_WIDTH:0]    shift_ext;
    logic [DATA_WIDTH-1:0]  data_n;
    logic                   vld_n;
    logic                   ferr_n;
    logic                   bit_end;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit, par_bit_n;
    logic                   perr_n;
`endif

    // All state, datapath and output pulses are registered here; the
    // combinational process below decides every next value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_vld     <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            rx_data    <= data_n;
            rx_vld     <= vld_n;
            frame_err  <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= perr_n;
`endif
        end
    end

    assign bit_end   = (cnt == BIT_LAST);
    // New bit enters at the MSB so that after DATA_WIDTH shifts the first
    // (least significant) bit has reached bit 0.
    assign shift_ext = {rxs, shift};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        data_n    = rx_data;
        vld_n     = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        perr_n    = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end

            ST_START: begin
                // The line returning high before mid-start-bit is a glitch;
                // dropping back to IDLE at once keeps busy short for noise.
                if (rxs) begin
                    state_n = ST_IDLE;
                end else if (cnt == HALF_LAST) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift_ext[DATA_WIDTH:1];
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    par_bit_n = rxs;
                    state_n   = ST_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (rxs) begin
                        state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data plus parity bit has an even
                        // number of ones.
                        if (^{shift, par_bit}) begin
                            perr_n = 1'b1;
                        end else begin
                            data_n = shift;
                            vld_n  = 1'b1;
                        end
`else
                        data_n = shift;
                        vld_n  = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                // A held-low line (break) must go high before a new start
                // bit can be recognised.
                if (rxs) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a frame-level reference model
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Falling edge to rx_vld: synchronizer, half bit, data+parity+stop bits,
    // one registered output cycle.
    localparam int LAT = 2 + CPB / 2 + (DW + 1 + PB) * CPB + 1;

    localparam int K_VLD  = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          rx_vld;
    logic [DW-1:0] rx_data;
    logic          frame_err;
    logic          busy;
    logic          parity_err;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
        int            t0;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] last_good = '0;
    logic          prev_pulse = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops the oldest expected event whenever the DUT pulses.
    always @(negedge clk) begin
        if (!rst) begin
            last_good  = '0;
            prev_pulse = 1'b0;
        end else begin
            int   n_hi;
            int   kind;
            exp_t e;
            n_hi = int'(rx_vld) + int'(frame_err) + int'(parity_err);
            if (n_hi != 0) begin
                kind = rx_vld ? K_VLD : (frame_err ? K_FERR : K_PERR);
                chk("pulses_exclusive", n_hi == 1, n_hi, 1);
                chk("pulse_one_cycle", !prev_pulse, int'(prev_pulse), 0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1'b0, kind, -1);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", kind == e.kind, kind, e.kind);
                    if (e.kind == K_VLD && kind == K_VLD) begin
                        chk("rx_data", rx_data == e.data, int'(rx_data), int'(e.data));
                        chk("latency", (cyc - e.t0 >= LAT - 1) && (cyc - e.t0 <= LAT + 1),
                            cyc - e.t0, LAT);
                        last_good = e.data;
                    end else begin
                        chk("rx_data_held", rx_data == last_good, int'(rx_data), int'(last_good));
                    end
                end
            end
            prev_pulse = (n_hi != 0);
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model at frame level: a low stop bit is a framing error,
    // otherwise a wrong parity bit is a parity error, otherwise good data.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic bad_par);
        exp_t e;
        e.data = d;
        e.t0   = cyc;
        if (!stop)                 e.kind = K_FERR;
        else if (PB == 1 && bad_par) e.kind = K_PERR;
        else                       e.kind = K_VLD;
        q.push_back(e);
        drive(1'b0, CPB);
        for (int i = 0; i < DW; i++) drive(d[i], CPB);
        if (PB == 1) drive((^d) ^ bad_par, CPB);
        drive(stop, CPB);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_vld"}, rx_vld == 1'b0, int'(rx_vld), 0);
        chk({tag, "_frame_err"}, frame_err == 1'b0, int'(frame_err), 0);
        chk({tag, "_busy"}, busy == 1'b0, int'(busy), 0);
        chk({tag, "_rx_data"}, rx_data == '0, int'(rx_data), 0);
        chk({tag, "_parity_err"}, parity_err == 1'b0, int'(parity_err), 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          stop;
        int            waited;

        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        drive(1'b1, 4);

        // Single 0x55 frame.
        send_frame(8'h55, 1'b1, 1'b0);
        drive(1'b1, 2 * CPB);

        // Back-to-back frames, no idle gap.
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 2 * CPB);

        // Five-cycle glitch on the idle line.
        drive(1'b0, 5);
        chk("glitch_busy_high", busy == 1'b1, int'(busy), 1);
        drive(1'b1, 3);
        chk("glitch_busy_low", busy == 1'b0, int'(busy), 0);
        drive(1'b1, 12 * CPB);

        // Bad stop bit followed by a long break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 40 * CPB);
        drive(1'b1, CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1, 2 * CPB);

        // Reset in the middle of data bit 4 of 0x7E.
        d = 8'h7E;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(d[i], CPB);
        drive(d[4], CPB / 2);
        rst = 1'b0;
        #2;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_busy_hold", busy == 1'b0, int'(busy), 0);
        rx  = 1'b1;
        rst = 1'b1;
        drive(1'b1, 3 * CPB);
        send_frame(8'h12, 1'b1, 1'b0);
        drive(1'b1, 2 * CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drive(1'b1, 2 * CPB);
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 2 * CPB);
`endif

        // Randomised frames with occasional bad stop bits and random gaps.
        for (int n = 0; n < 24; n++) begin
            d    = DW'($urandom);
            stop = ($urandom_range(5) != 0);
            send_frame(d, stop, 1'b0);
            if (!stop) drive(1'b1, CPB);
            drive(1'b1, $urandom_range(2 * CPB));
        end

        waited = 0;
        while (q.size() != 0 && waited < 4000) begin
            @(posedge clk);
            waited++;
        end
        drive(1'b1, 4 * CPB);
        chk("queue_drained", q.size() == 0, q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
